// File: rtl/dsp_req_sched.sv
// Two-requester scheduler in front of a shared DSP multiplier. Narrow
// operations (b[8:5]==0) use mode 0 and may issue back to back; wide
// operations use mode 1 and are followed by one idle cycle. A mode change
// with results still in flight waits in DRAIN until the pipeline is empty.
// A tag pipeline routes each product back to the requester that issued it.
module dsp_req_sched #(
  parameter int N   = 9,
  parameter int M   = 9,
  parameter int LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  input  logic           req1_valid,
  output logic           req0_ready,
  output logic           req1_ready,
  input  logic [4:0]     req0_a,
  input  logic [4:0]     req1_a,
  input  logic [8:0]     req0_b,
  input  logic [8:0]     req1_b,
  output logic           dsp_start,
  output logic [1:0]     dsp_mode,
  output logic [N-1:0]   dsp_aa,
  output logic [M-1:0]   dsp_bb,
  output logic [N+M-1:0] dsp_cc,
  input  logic [N+M-1:0] dsp_out,
  output logic           rsp0_valid,
  output logic           rsp1_valid,
  output logic [14:0]    rsp0_data,
  output logic [14:0]    rsp1_data,
  output logic           busy
);

  localparam int CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {RUN, GAP, DRAIN} state_t;

  state_t         state_q, state_d;
  logic           prio_q;
  logic           mode_q;
  logic [N-1:0]   aa_q;
  logic [M-1:0]   bb_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [LAT-1:0] tagValid_q, tagId_q, tagMode_q;

  logic       anyValid, sel, selWide, modeOk, grant, retire;
  logic [4:0] selA;
  logic [8:0] selB;
  logic [14:0] rspData;

  // Arbitration: pick the requester (round-robin on contention) and decide whether it may issue now.
  always_comb begin
    anyValid = req0_valid | req1_valid;
    sel      = req0_valid ? (req1_valid ? prio_q : 1'b0) : 1'b1;
    selA     = sel ? req1_a : req0_a;
    selB     = sel ? req1_b : req0_b;
    selWide  = |selB[8:5];
    modeOk   = (selWide == mode_q) || (cnt_q == '0);
    grant    = !rst && (state_q == RUN) && anyValid && modeOk;
    retire   = tagValid_q[LAT-1];
    cnt_d    = cnt_q + CW'(grant) - CW'(retire);
  end

  // Next-state logic: wide issue forces a one-cycle GAP, a blocked mode change waits in DRAIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (anyValid) begin
          if (grant) state_d = selWide ? GAP : RUN;
          else       state_d = DRAIN;
        end
      end
      GAP:     state_d = RUN;
      DRAIN:   if (cnt_d == '0) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Output drive: fresh operands on issue, otherwise hold the last issued operands and mode.
  always_comb begin
    req0_ready = grant && !sel;
    req1_ready = grant && sel;
    dsp_start  = grant;
    dsp_aa     = grant ? N'(selA) : aa_q;
    dsp_bb     = grant ? M'(selB) : bb_q;
    dsp_mode   = {1'b0, grant ? selWide : mode_q};
    dsp_cc     = '0;
    busy       = (cnt_q != '0) || (state_q != RUN);
    rspData    = tagMode_q[LAT-1] ? dsp_out[14:0] : {5'b0, dsp_out[9:0]};
    rsp0_valid = retire && !tagId_q[LAT-1];
    rsp1_valid = retire && tagId_q[LAT-1];
    rsp0_data  = rsp0_valid ? rspData : '0;
    rsp1_data  = rsp1_valid ? rspData : '0;
  end

  // State registers, held operands, in-flight count and the tag pipeline; reset discards in-flight work.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      prio_q     <= 1'b0;
      mode_q     <= 1'b0;
      aa_q       <= '0;
      bb_q       <= '0;
      cnt_q      <= '0;
      tagValid_q <= '0;
      tagId_q    <= '0;
      tagMode_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (grant) begin
        prio_q <= ~sel;
        mode_q <= selWide;
        aa_q   <= dsp_aa;
        bb_q   <= dsp_bb;
      end
      tagValid_q[0] <= grant;
      tagId_q[0]    <= sel;
      tagMode_q[0]  <= selWide;
      for (int i = 1; i < LAT; i++) begin
        tagValid_q[i] <= tagValid_q[i-1];
        tagId_q[i]    <= tagId_q[i-1];
        tagMode_q[i]  <= tagMode_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_dsp_req_sched.sv
// Bench for dsp_req_sched with a behavioural DSP model. Drivers push the
// expected product and arrival cycle into per-requester queues on every
// handshake; a monitor pops and compares whenever a response appears.
module tb_dsp_req_sched;

  localparam int N   = 9;
  localparam int M   = 9;
  localparam int LAT = 3;

  typedef struct { logic [4:0] a; logic [8:0] b; } op_t;
  typedef struct { logic [14:0] data; int due; } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0_valid, req1_valid, req0_ready, req1_ready;
  logic [4:0]     req0_a, req1_a;
  logic [8:0]     req0_b, req1_b;
  logic           dsp_start;
  logic [1:0]     dsp_mode;
  logic [N-1:0]   dsp_aa;
  logic [M-1:0]   dsp_bb;
  logic [N+M-1:0] dsp_cc, dsp_out;
  logic           rsp0_valid, rsp1_valid;
  logic [14:0]    rsp0_data, rsp1_data;
  logic           busy;

  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   tbInflight = 0;
  int   rspSeen = 0;
  logic prevStart = 1'b0;
  logic prevMode = 1'b0;
  logic lastMode = 1'b0;

  op_t  ops0[$], ops1[$];
  exp_t exp0[$], exp1[$];
  int   gId[$], gCyc[$];

  logic [4:0] aTab [10] = '{5'd3, 5'd31, 5'd0, 5'd17, 5'd1, 5'd12, 5'd30, 5'd8, 5'd25, 5'd19};
  logic [8:0] bTab [10] = '{9'd5, 9'd31, 9'd17, 9'd0, 9'd1, 9'd25, 9'd7, 9'd16, 9'd29, 9'd2};

  logic [N+M-1:0] pipe [LAT];

  dsp_req_sched #(.N(N), .M(M), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
    .dsp_start(dsp_start), .dsp_mode(dsp_mode), .dsp_aa(dsp_aa), .dsp_bb(dsp_bb),
    .dsp_cc(dsp_cc), .dsp_out(dsp_out),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_data(rsp0_data), .rsp1_data(rsp1_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Cycle counter used to timestamp issues and responses.
  always @(posedge clk) cyc <= cyc + 1;

  // DSP model: mode 1 gives the full product, mode 0 only a valid low 10-bit field; idle cycles output junk.
  always @(posedge clk) begin
    if (dsp_start)
      pipe[0] <= dsp_mode[0] ? ((N+M)'(dsp_aa) * (N+M)'(dsp_bb))
                             : {8'hB5, 10'(dsp_aa[4:0] * dsp_bb[4:0])};
    else
      pipe[0] <= '1;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign dsp_out = pipe[LAT-1];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, req);
  endtask

  task automatic drive(input int id, input logic v, input op_t op);
    if (id == 0) begin req0_valid = v; req0_a = op.a; req0_b = op.b; end
    else         begin req1_valid = v; req1_a = op.a; req1_b = op.b; end
  endtask

  // Present each queued operation for one requester, hold it until granted, and record the expectation.
  task automatic applyStimulus(input int id);
    op_t  op;
    exp_t e;
    int   waitCyc;
    logic rdy;
    while ((id == 0 ? ops0.size() : ops1.size()) > 0) begin
      if (id == 0) op = ops0.pop_front();
      else         op = ops1.pop_front();
      @(posedge clk); #1;
      drive(id, 1'b1, op);
      waitCyc = 0;
      do begin
        @(negedge clk);
        waitCyc++;
        rdy = (id == 0) ? req0_ready : req1_ready;
      end while (!rdy && waitCyc < 50);
      if (!rdy) checkOutput("grant_timeout", 0, 1);
      else begin
        e.data = 15'(op.a) * 15'(op.b);
        e.due  = cyc + LAT;
        if (id == 0) exp0.push_back(e);
        else         exp1.push_back(e);
        gId.push_back(id);
        gCyc.push_back(cyc);
      end
    end
    @(posedge clk); #1;
    drive(id, 1'b0, op);
  endtask

  task automatic waitIdle();
    int n = 0;
    do begin @(negedge clk); n++; end
    while ((exp0.size() != 0 || exp1.size() != 0 || busy) && n < 100);
    if (n >= 100) checkOutput("idle_timeout", 0, 1);
  endtask

  // Monitor: handshake/issue sanity every cycle and scoreboard comparison of every response.
  always @(negedge clk) begin
    exp_t e;
    if (rsp0_valid || rsp1_valid) rspSeen++;
    if (rst) begin
      exp0.delete(); exp1.delete();
      tbInflight = 0; prevStart = 1'b0; prevMode = 1'b0; lastMode = 1'b0;
    end else begin
      checkOutput("start_vs_handshake", {dsp_start, req0_ready & req1_ready},
                  {(req0_valid & req0_ready) | (req1_valid & req1_ready), 1'b0});
      if (dsp_start) begin
        checkOutput("issue_fields", {dsp_aa[8:5], dsp_cc, dsp_mode},
                    {4'b0, 18'b0, 1'b0, |dsp_bb[8:5]});
        if (prevStart) checkOutput("mode1_back_to_back", prevMode, 0);
        if (dsp_mode[0] != lastMode) checkOutput("switch_with_inflight", tbInflight, 0);
        lastMode = dsp_mode[0];
      end
      if (rsp0_valid && rsp1_valid) checkOutput("dual_rsp", 1, 0);
      if (rsp0_valid) begin
        if (exp0.size() == 0) checkOutput("rsp0_unexpected", 1, 0);
        else begin
          e = exp0.pop_front();
          checkOutput("rsp0_data_cycle", {rsp0_data, 32'(cyc)}, {e.data, 32'(e.due)});
        end
      end
      if (rsp1_valid) begin
        if (exp1.size() == 0) checkOutput("rsp1_unexpected", 1, 0);
        else begin
          e = exp1.pop_front();
          checkOutput("rsp1_data_cycle", {rsp1_data, 32'(cyc)}, {e.data, 32'(e.due)});
        end
      end
      tbInflight = tbInflight + (dsp_start ? 1 : 0) - ((rsp0_valid || rsp1_valid) ? 1 : 0);
      prevStart = dsp_start;
      prevMode  = dsp_mode[0];
    end
  end

  // Hard stop in case something wedges beyond every per-wait bound.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got hang expected finish");
    $fatal(1, "[TB] timeout");
  end

  // Directed scenario sequence.
  initial begin
    logic [7:0] seq;
    int seenBefore;
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 5'd7; req0_b = 9'd9;
    req1_valid = 1'b0; req1_a = '0;   req1_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ready", {req0_ready, req1_ready}, 0);
    checkOutput("reset_outputs", {dsp_start, dsp_aa, dsp_bb, dsp_cc, dsp_mode, busy}, 0);
    checkOutput("reset_rsp", {rsp0_valid, rsp1_valid, rsp0_data, rsp1_data}, 0);
    @(posedge clk); #1;
    rst = 1'b0; req0_valid = 1'b0;

    // Narrow stream on requester 0: one issue per cycle.
    for (int i = 0; i < 10; i++) ops0.push_back(op_t'{aTab[i], bTab[i]});
    gId.delete(); gCyc.delete();
    applyStimulus(0);
    waitIdle();
    checkOutput("narrow_b2b", gCyc[9] - gCyc[0], 9);

    // Wide stream on requester 1: issues every other cycle.
    repeat (3) ops1.push_back(op_t'{5'd31, 9'd511});
    gId.delete(); gCyc.delete();
    applyStimulus(1);
    waitIdle();
    checkOutput("wide_spacing", {32'(gCyc[1] - gCyc[0]), 32'(gCyc[2] - gCyc[1])}, {32'd2, 32'd2});

    // Both requesters narrow and continuously valid: grants alternate starting with req0.
    for (int i = 0; i < 4; i++) begin
      ops0.push_back(op_t'{aTab[i], bTab[i]});
      ops1.push_back(op_t'{aTab[9-i], bTab[9-i]});
    end
    gId.delete(); gCyc.delete();
    fork
      applyStimulus(0);
      applyStimulus(1);
    join
    waitIdle();
    seq = '0;
    for (int i = 0; i < 8; i++) seq = {seq[6:0], gId[i][0]};
    checkOutput("rr_order", seq, 8'b0101_0101);
    checkOutput("rr_b2b", gCyc[7] - gCyc[0], 7);

    // Three narrow in flight, then a wide: drain before the mode switch.
    ops0.push_back(op_t'{5'd5, 9'd9});
    ops0.push_back(op_t'{5'd7, 9'd11});
    ops0.push_back(op_t'{5'd2, 9'd30});
    ops0.push_back(op_t'{5'd19, 9'd300});
    gId.delete(); gCyc.delete();
    applyStimulus(0);
    waitIdle();
    checkOutput("drain_delay", gCyc[3] - gCyc[2], LAT + 1);

    // Reset one cycle after an issue: the in-flight result must be dropped.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 5'd21; req0_b = 9'd21;
    @(negedge clk);
    checkOutput("rst_phase_grant", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seenBefore = rspSeen;
    repeat (8) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_no_rsp", rspSeen - seenBefore, 0);
    checkOutput("rst_outputs", {dsp_start, dsp_aa, dsp_bb, dsp_cc, dsp_mode, busy,
                                rsp0_valid, rsp1_valid, rsp0_data, rsp1_data}, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
